// File: rtl/uart_rx_word_fifo.sv
// uart_rx_word_fifo: packs bytes from a UART receiver into little-endian
// 32-bit words and buffers them in a show-ahead FIFO with sticky error flags.
module uart_rx_word_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_ferr,
  input  logic                     clear,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     ferr_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic          rx_ready_q;
  logic [1:0]    byte_idx;
  logic [7:0]    lane [3];
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          strobe;
  logic          good_byte;
  logic          bad_byte;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          drop;
  logic [31:0]   push_word;
  logic [CW-1:0] count_next;

  // rx_ready is a level; only its rising edge delivers a byte.
  assign strobe    = rx_ready & ~rx_ready_q;
  assign good_byte = strobe & ~rx_ferr & ~clear;
  assign bad_byte  = strobe &  rx_ferr & ~clear;
  assign push_req  = good_byte & (byte_idx == 2'd3);

  assign word_valid = (count != '0);
  assign full       = (count == FULL_COUNT);
  assign pop        = word_valid & word_ready & ~clear;
  // A full FIFO still accepts the word if a slot frees up on the same edge.
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  assign push_word = {rx_data, lane[2], lane[1], lane[0]};
  assign word_data = mem[rd_ptr];

  // Capture the three lower byte lanes of the word under assembly.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (good_byte && byte_idx == 2'(gi)) begin
          lane[gi] <= rx_data;
        end
      end
    end
  endgenerate

  // Word storage is written only on an accepted push and is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Control state: edge detector, byte index, pointers, count, sticky flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_ready_q <= 1'b0;
      byte_idx   <= 2'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      ferr_seen  <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (clear) begin
        byte_idx  <= 2'd0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        ferr_seen <= 1'b0;
      end else begin
        if (bad_byte) begin
          byte_idx  <= 2'd0;
          ferr_seen <= 1'b1;
        end else if (good_byte) begin
          byte_idx <= byte_idx + 2'd1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Testbench for uart_rx_word_fifo: directed byte sequences, expected words
// queued at stimulus time and compared by an independent output monitor.
module tb_uart_rx_word_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ferr_seen;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  uart_rx_word_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .clear      (clear),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .count      (count),
    .overflow   (overflow),
    .ferr_seen  (ferr_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f, input int hold);
    rx_data  = b;
    rx_ferr  = f;
    rx_ready = 1'b1;
    repeat (hold) tick();
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, 2);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    word_ready = 1'b1;
    while (count != '0 && budget < 200) begin
      tick();
      budget++;
    end
    word_ready = 1'b0;
    chk("drain_done", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every cycle the DUT will pop, compare its head with the scoreboard.
  always @(negedge clk) begin
    if (rstn && !clear && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", word_data);
      end else begin
        chk("word", word_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(word_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_ferr", 32'(ferr_seen), 32'd0);
    rstn = 1'b1;
    tick();

    // Basic word with long rx_ready highs; check one-cycle push latency.
    send_byte(8'h11, 1'b0, 5);
    send_byte(8'h22, 1'b0, 5);
    send_byte(8'h33, 1'b0, 5);
    exp_q.push_back(32'h44332211);
    rx_data = 8'h44;
    rx_ready = 1'b1;
    chk("pre4_valid", 32'(word_valid), 32'd0);
    tick();
    chk("post4_valid", 32'(word_valid), 32'd1);
    chk("post4_count", 32'(count), 32'd1);
    repeat (4) tick();
    rx_ready = 1'b0;
    tick();
    chk("single_count", 32'(count), 32'd1);
    drain();

    // Framing error discards the partial word.
    send_byte(8'hAA, 1'b0, 2);
    send_byte(8'hBB, 1'b0, 2);
    send_byte(8'hCC, 1'b1, 2);
    exp_q.push_back(32'h04030201);
    send_word(32'h04030201);
    chk("ferr_seen", 32'(ferr_seen), 32'd1);
    chk("ferr_count", 32'(count), 32'd1);
    drain();
    chk("ferr_sticky", 32'(ferr_seen), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ferr_cleared", 32'(ferr_seen), 32'd0);

    // Overflow: DEPTH+1 words with no consumer.
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back(32'hA0B0C000 + 32'(i));
      send_word(32'hA0B0C000 + 32'(i));
    end
    chk("ovf_count", 32'(count), DEPTH);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, 4th strobe coincides with a pop: no overflow.
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'h5000_0000 + 32'(i));
      send_word(32'h5000_0000 + 32'(i));
    end
    chk("full_count", 32'(count), DEPTH);
    exp_q.push_back(32'h87654321);
    send_byte(8'h21, 1'b0, 2);
    send_byte(8'h43, 1'b0, 2);
    send_byte(8'h65, 1'b0, 2);
    rx_data = 8'h87;
    rx_ready = 1'b1;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    rx_ready = 1'b0;
    tick();
    chk("pp_count", 32'(count), DEPTH);
    chk("pp_overflow", 32'(overflow), 32'd0);
    drain();

    // Reset in the middle of a word.
    send_byte(8'h55, 1'b0, 2);
    send_byte(8'h66, 1'b0, 2);
    rstn = 1'b0;
    #1;
    chk("rst_async_count", 32'(count), 32'd0);
    tick();
    chk("rst_valid", 32'(word_valid), 32'd0);
    rstn = 1'b1;
    tick();
    exp_q.push_back(32'h0D0C0B0A);
    send_word(32'h0D0C0B0A);
    chk("rst_word_count", 32'(count), 32'd1);
    drain();

    // Clear on the 4th strobe with count=3 and overflow set.
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back(32'hC1C2C300 + 32'(i));
      send_word(32'hC1C2C300 + 32'(i));
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("clr_pre_count", 32'(count), 32'd3);
    chk("clr_pre_overflow", 32'(overflow), 32'd1);
    send_byte(8'hE1, 1'b0, 2);
    send_byte(8'hE2, 1'b0, 2);
    send_byte(8'hE3, 1'b0, 2);
    rx_data = 8'hE4;
    rx_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(word_valid), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    repeat (2) tick();
    rx_ready = 1'b0;
    tick();
    chk("clr_discard_count", 32'(count), 32'd0);
    exp_q.push_back(32'hF4F3F2F1);
    send_word(32'hF4F3F2F1);
    chk("clr_after_count", 32'(count), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_fifo.md
UART_RX_WORD_FIFO -- requirements
Module: uart_rx_word_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 32-bit word entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  byte from the UART receiver, stable while rx_ready is high.
REQ-005 SHALL have port rx_ready  input  1  UART receiver byte-done level; it may stay high for many cycles.
REQ-006 SHALL have port rx_ferr  input  1  framing error for the byte flagged by rx_ready.
REQ-007 SHALL have port clear  input  1  synchronous flush of the assembler, FIFO and sticky flags.
REQ-008 SHALL have port word_data  output  32  word at the FIFO head (show-ahead).
REQ-009 SHALL have port word_valid  output  1  FIFO not empty.
REQ-010 SHALL have port word_ready  input  1  consumer accepts word_data when word_valid is high.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.
REQ-013 SHALL have port ferr_seen  output  1  sticky flag: a byte with a framing error was received.

Function
REQ-014 SHALL register rx_ready as rx_ready_q; byte strobe = rx_ready & ~rx_ready_q, so each high period of rx_ready yields exactly one byte.
REQ-015 SHALL ignore rx_data and rx_ferr in any cycle without a strobe.
REQ-016 On a strobe with rx_ferr=1, SHALL discard the byte, set ferr_seen, and reset the byte index to 0, discarding any partial word.
REQ-017 On a strobe with rx_ferr=0, SHALL store rx_data in byte lane byte_idx (lane 0 = bits [7:0], little-endian) and increment byte_idx (2 bits, wraps 3->0).
REQ-018 When the strobe delivers lane 3, SHALL form the word {rx_data, lane2, lane1, lane0} and push it on that same clock edge; word_valid SHALL be high in the next cycle (one-cycle latency from the 4th strobe).
REQ-019 SHALL pop when word_valid & word_ready; word_data and word_valid SHALL reflect the new head in the next cycle.
REQ-020 A push SHALL succeed if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle; count is then unchanged.
REQ-021 A push to a full FIFO without a simultaneous pop SHALL drop the word, set overflow, leave the FIFO contents intact, and still reset byte_idx to 0.
REQ-022 A simultaneous push and pop on an empty FIFO SHALL NOT pop (word_valid is low); the word SHALL be stored.
REQ-023 Read and write pointers SHALL each be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-024 word_data SHALL be don't-care while word_valid is low.
REQ-025 overflow and ferr_seen SHALL stay high until clear or reset.
REQ-026 clear SHALL take priority over a strobe, push and pop in the same cycle: pointers, count, byte_idx and sticky flags go to 0, and that cycle's byte is discarded; rx_ready_q still updates.

Reset
REQ-027 While rstn is low, SHALL asynchronously force rx_ready_q=0, byte_idx=0, pointers=0, count=0, word_valid=0, overflow=0 and ferr_seen=0; word storage is not reset.
REQ-028 Deassertion of rstn mid-word SHALL leave no partial word: the first byte after reset lands in lane 0.

Verification
REQ-029 SHALL cover: bytes 0x11,0x22,0x33,0x44, each with rx_ready high for 5 cycles -> one word 0x44332211, word_valid high one cycle after the 4th strobe, count=1.
REQ-030 SHALL cover: bytes 0xAA,0xBB, then 0xCC with rx_ferr=1, then 0x01,0x02,0x03,0x04 -> ferr_seen=1 and the only word is 0x04030201.
REQ-031 SHALL cover: word_ready=0 while DEPTH+1 words are sent -> count=DEPTH, overflow=1, and a drain returns the first DEPTH words in order.
REQ-032 SHALL cover: FIFO full, with the 4th strobe coinciding with word_ready=1 -> no overflow, count stays DEPTH, and the new word is read last.
REQ-033 SHALL cover: rstn pulsed low after 2 bytes, then 4 bytes 0x0A..0x0D -> word 0x0D0C0B0A, count=1.
REQ-034 SHALL cover: clear asserted in the same cycle as the 4th strobe with count=3 and overflow=1 -> count=0, word_valid=0, overflow=0, and the byte is discarded.
